// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and counter type for the
// sync generator, the pattern stage and the bench.
package vga_timing_pkg;

    localparam int HPERIOD = 800;
    localparam int HFRONT  = 16;
    localparam int HWIDTH  = 96;
    localparam int HBACK   = 48;
    localparam int VPERIOD = 525;
    localparam int VFRONT  = 10;
    localparam int VWIDTH  = 2;
    localparam int VBACK   = 33;

    localparam int HACTIVE = HPERIOD - HFRONT - HWIDTH - HBACK;
    localparam int VACTIVE = VPERIOD - VFRONT - VWIDTH - VBACK;

    localparam int CNT_W  = 10;
    localparam int FCNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_syncgen_if.sv
// Video timing bundle: pixel counters plus registered HS/VS/DE strobes.
// The sync generator drives the master side, the pattern stage reads the slave side.
interface vga_syncgen_if #(
    parameter int CNT_W = vga_timing_pkg::CNT_W
);
    import vga_timing_pkg::*;

    logic [CNT_W-1:0]  HCNT;
    logic [CNT_W-1:0]  VCNT;
    logic              HS;
    logic              VS;
    logic              DE;
    logic              FSTART;
    logic [FCNT_W-1:0] FRAMECNT;

    modport master (
        output HCNT, VCNT, HS, VS, DE, FSTART, FRAMECNT
    );

    modport slave (
        input HCNT, VCNT, HS, VS, DE, FSTART, FRAMECNT
    );

endinterface

// File: rtl/vga_syncgen.sv
// Free-running VGA timing generator; strobes lag the counters by one clock.
// Optional completed-frame counter enabled by SYNCGEN_FRAMECNT_EN.
module vga_syncgen #(
    parameter int HPERIOD = vga_timing_pkg::HPERIOD,
    parameter int HFRONT  = vga_timing_pkg::HFRONT,
    parameter int HWIDTH  = vga_timing_pkg::HWIDTH,
    parameter int HBACK   = vga_timing_pkg::HBACK,
    parameter int VPERIOD = vga_timing_pkg::VPERIOD,
    parameter int VFRONT  = vga_timing_pkg::VFRONT,
    parameter int VWIDTH  = vga_timing_pkg::VWIDTH,
    parameter int VBACK   = vga_timing_pkg::VBACK,
    parameter int CNT_W   = vga_timing_pkg::CNT_W
) (
    input  logic          CLK,
    input  logic          RST,
    vga_syncgen_if.master vid
);
    import vga_timing_pkg::*;

    localparam int HACT = HPERIOD - HFRONT - HWIDTH - HBACK;
    localparam int VACT = VPERIOD - VFRONT - VWIDTH - VBACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HPERIOD - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VPERIOD - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(HACT);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(VACT);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(HACT + HFRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(HACT + HFRONT + HWIDTH - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(VACT + VFRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(VACT + VFRONT + VWIDTH - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             fstart_q, fstart_d;
    logic             hwrap, vwrap;

    always_comb begin
        hwrap  = (hcnt_q == H_LAST);
        vwrap  = (vcnt_q == V_LAST);
        hcnt_d = hwrap ? '0 : hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (hwrap) begin
            vcnt_d = vwrap ? '0 : vcnt_q + CNT_W'(1);
        end
    end

    // Decode the current counters; registering it yields the one-clock lag.
    always_comb begin
        de_d     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_d     = !((hcnt_q >= HS_BEG) && (hcnt_q <= HS_END));
        vs_d     = !((vcnt_q >= VS_BEG) && (vcnt_q <= VS_END));
        fstart_d = (hcnt_q == '0) && (vcnt_q == '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            fstart_q <= fstart_d;
        end
    end

`ifdef SYNCGEN_FRAMECNT_EN
    logic              fseen_q, fseen_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // The first frame start after reset only arms the counter.
    always_comb begin
        fseen_d = fseen_q | fstart_d;
        fcnt_d  = fcnt_q;
        if (fstart_d && fseen_q) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fseen_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            fseen_q <= fseen_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign vid.FRAMECNT = fcnt_q;
`else
    assign vid.FRAMECNT = '0;
`endif

    assign vid.HCNT   = hcnt_q;
    assign vid.VCNT   = vcnt_q;
    assign vid.HS     = hs_q;
    assign vid.VS     = vs_q;
    assign vid.DE     = de_q;
    assign vid.FSTART = fstart_q;

endmodule

// File: tb/tb_vga_syncgen.sv
// Directed bench: full 640x480 line timing on one instance, frame timing,
// wrap, frame counter and mid-frame reset on a scaled 40x30 instance.
module tb_vga_syncgen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_syncgen_if vid_a ();
    vga_syncgen_if vid_b ();

    vga_syncgen u_dut_a (
        .CLK (clk),
        .RST (rst_a),
        .vid (vid_a.master)
    );

    // Scaled timing: HACT 24, HS low 28..33; VACT 22, VS low 24..25.
    vga_syncgen #(
        .HPERIOD (40),
        .HFRONT  (4),
        .HWIDTH  (6),
        .HBACK   (6),
        .VPERIOD (30),
        .VFRONT  (2),
        .VWIDTH  (2),
        .VBACK   (4),
        .CNT_W   (10)
    ) u_dut_b (
        .CLK (clk),
        .RST (rst_b),
        .vid (vid_b.master)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] pack_a();
        return {vid_a.HCNT, vid_a.VCNT, vid_a.HS, vid_a.VS,
                vid_a.DE, vid_a.FSTART, vid_a.FRAMECNT};
    endfunction

    function automatic logic [39:0] pack_b();
        return {vid_b.HCNT, vid_b.VCNT, vid_b.HS, vid_b.VS,
                vid_b.DE, vid_b.FSTART, vid_b.FRAMECNT};
    endfunction

    localparam logic [39:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1,
                                       1'b0, 1'b0, 16'd0};

    initial begin
        int   de_cnt, de_rise1, de_rise2, hs_fall, hs_rise;
        int   fs_cnt, vs_low, fc_max, rst_bad;
        int   de_rises, vs_fall, vs_rise, fs_n;
        int   fs_k [4];
        int   fs_fc [4];
        logic de_p, hs_p, vs_p;
        cnt_t ph, pv, vf_h, vf_v;
        bit   found;

        // Reset hold: every sample must show reset values.
        rst_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pack_a() !== RST_VEC) rst_bad++;
        end
        chk("rst_hold_a", pack_a(), RST_VEC);
        chk("rst_hold_bad", rst_bad, 0);

        @(negedge clk);
        rst_a = 1'b1;

        de_cnt = 0; de_rise1 = 0; de_rise2 = 0;
        hs_fall = 0; hs_rise = 0; fs_cnt = 0;
        vs_low = 0; fc_max = 0;
        de_p = 1'b0; hs_p = 1'b1;
        for (int k = 1; k <= 1700; k++) begin
            tick();
            if (k == 1) begin
                chk("rel_hcnt", vid_a.HCNT, 1);
                chk("rel_vcnt", vid_a.VCNT, 0);
                chk("rel_de", vid_a.DE, 1);
                chk("rel_fstart", vid_a.FSTART, 1);
                chk("rel_hs", vid_a.HS, 1);
                chk("rel_vs", vid_a.VS, 1);
            end
            if (k == 799) begin
                chk("h799_hcnt", vid_a.HCNT, 799);
                chk("h799_vcnt", vid_a.VCNT, 0);
            end
            if (k == 800) begin
                chk("lwrap_hcnt", vid_a.HCNT, 0);
                chk("lwrap_vcnt", vid_a.VCNT, 1);
            end
            if (vid_a.DE && !de_p) begin
                if (de_rise1 == 0) de_rise1 = k;
                else if (de_rise2 == 0) de_rise2 = k;
            end
            if (k <= 800 && vid_a.DE) de_cnt++;
            if (!vid_a.HS && hs_p && hs_fall == 0) hs_fall = k;
            if (vid_a.HS && !hs_p && hs_rise == 0) hs_rise = k;
            if (vid_a.FSTART) fs_cnt++;
            if (!vid_a.VS) vs_low++;
            if (int'(vid_a.FRAMECNT) > fc_max) fc_max = int'(vid_a.FRAMECNT);
            de_p = vid_a.DE;
            hs_p = vid_a.HS;
        end
        chk("de_rise1", de_rise1, 1);
        chk("de_per_line", de_cnt, 640);
        chk("hs_fall", hs_fall, 657);
        chk("hs_width", hs_rise - hs_fall, 96);
        chk("line_period", de_rise2 - de_rise1, 800);
        chk("fs_once", fs_cnt, 1);
        chk("vs_idle", vs_low, 0);
        chk("fc_first", fc_max, 0);

        // Scaled instance: three-plus frames of 1200 clocks.
        chk("rst_hold_b", pack_b(), RST_VEC);
        @(negedge clk);
        rst_b = 1'b1;

        de_cnt = 0; de_rises = 0; vs_fall = 0; vs_rise = 0; fs_n = 0;
        de_p = 1'b0; vs_p = 1'b1;
        ph = '0; pv = '0; vf_h = '1; vf_v = '1;
        for (int i = 0; i < 4; i++) begin
            fs_k[i] = 0;
            fs_fc[i] = -1;
        end
        for (int k = 1; k <= 3650; k++) begin
            tick();
            if (k <= 1200) begin
                if (vid_b.DE) de_cnt++;
                if (vid_b.DE && !de_p) de_rises++;
                if (!vid_b.VS && vs_p && vs_fall == 0) begin
                    vs_fall = k;
                    vf_h = ph;
                    vf_v = pv;
                end
                if (vid_b.VS && !vs_p && vs_rise == 0) vs_rise = k;
            end
            if (k == 1199) begin
                chk("fw_hcnt_last", vid_b.HCNT, 39);
                chk("fw_vcnt_last", vid_b.VCNT, 29);
            end
            if (k == 1200) begin
                chk("fw_hcnt_0", vid_b.HCNT, 0);
                chk("fw_vcnt_0", vid_b.VCNT, 0);
                chk("fw_fs_wait", vid_b.FSTART, 0);
            end
            if (k == 1201) chk("fw_fs", vid_b.FSTART, 1);
            if (vid_b.FSTART && fs_n < 4) begin
                fs_k[fs_n] = k;
                fs_fc[fs_n] = int'(vid_b.FRAMECNT);
                fs_n++;
            end
            de_p = vid_b.DE;
            vs_p = vid_b.VS;
            ph = vid_b.HCNT;
            pv = vid_b.VCNT;
        end
        chk("de_px_frame", de_cnt, 528);
        chk("de_lines", de_rises, 22);
        chk("vs_fall", vs_fall, 961);
        chk("vs_fall_h", vf_h, 0);
        chk("vs_fall_v", vf_v, 24);
        chk("vs_width", vs_rise - vs_fall, 80);
        chk("fs_count", fs_n, 4);
        chk("fs_first", fs_k[0], 1);
        chk("fs_period1", fs_k[1] - fs_k[0], 1200);
        chk("fs_period2", fs_k[2] - fs_k[1], 1200);
`ifdef SYNCGEN_FRAMECNT_EN
        chk("fc0", fs_fc[0], 0);
        chk("fc1", fs_fc[1], 1);
        chk("fc2", fs_fc[2], 2);
`else
        chk("fc0", fs_fc[0], 0);
        chk("fc1", fs_fc[1], 0);
        chk("fc2", fs_fc[2], 0);
`endif

        // Mid-frame reset, asserted away from any clock edge.
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            tick();
            if (vid_b.VCNT == 10'd10 && vid_b.HCNT == 10'd15) found = 1'b1;
        end
        chk("mid_found", found, 1);
        rst_b = 1'b0;
        #1;
        chk("mid_async", pack_b(), RST_VEC);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_hold", pack_b(), RST_VEC);
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        chk("mid_rel_hcnt", vid_b.HCNT, 1);
        chk("mid_rel_vcnt", vid_b.VCNT, 0);
        chk("mid_rel_de", vid_b.DE, 1);
        chk("mid_rel_fs", vid_b.FSTART, 1);
        chk("mid_rel_fc", vid_b.FRAMECNT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
